// File: rtl/wb_hash_ctrl_gen2_if.sv
// wb_hash_ctrl_gen2_if: Wishbone classic bus bundle between a bus master and the hash controller slave.
interface wb_hash_ctrl_gen2_if #(
    parameter int AW = 32
);
    logic [AW-1:0] wb_adr_i;
    logic [31:0]   wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic          wb_we_i;
    logic          wb_stb_i;
    logic          wb_cyc_i;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic          wb_err_o;
    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_hash_ctrl_gen2.sv
// wb_hash_ctrl_gen2: Wishbone slave holding a hash message block, start/ack control FSM and digest read-back.
module wb_hash_ctrl_gen2 #(
    parameter int BLOCK_WORDS  = 16,
    parameter int DIGEST_WORDS = 4,
    parameter int AW           = 32
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    wb_hash_ctrl_gen2_if.slave        wb,
    output logic                      int_o,
    output logic [32*BLOCK_WORDS-1:0] core_msg_o,
    output logic                      core_start_o,
    output logic                      core_newmsg_o,
    input  logic                      core_ready_i,
    input  logic [32*DIGEST_WORDS-1:0] core_digest_i,
    input  logic                      core_valid_i
);
    localparam int unsigned DIG_LO  = 2 + BLOCK_WORDS;
    localparam int unsigned NW      = 2 + BLOCK_WORDS + DIGEST_WORDS;
    localparam int          ADR_MSB = $clog2(NW) + 1;
    localparam int          IW      = ADR_MSB - 1;

    typedef enum logic [1:0] {IDLE, PEND, BUSY} state_t;

    state_t                         state_q, state_d;
    logic [BLOCK_WORDS-1:0][31:0]   msg_q, msg_d;
    logic [DIGEST_WORDS-1:0][31:0]  dig_q, dig_d;
    logic [31:0]                    dat_q, dat_d;
    logic                           ack_q, ack_d, err_q, err_d;
    logic                           done_q, done_d, ovr_q, ovr_d, ie_q, ie_d;
    logic                           start_q, start_d, newmsg_q, newmsg_d, lat_q, lat_d;

    logic [AW-1:0] adr;
    logic [IW-1:0] idx;
    logic [31:0]   idx_w, rdata, lane_mask;
    logic [31:0]   rmap [2**IW];
    logic          req, busy, is_msg, is_dig, bad, wr_ok, ctrl_wr, stat_wr, start_wr, capture;
    logic          unused_adr;

    assign adr        = wb.wb_adr_i;
    assign idx        = adr[ADR_MSB:2];
    assign idx_w      = 32'(idx);
    assign unused_adr = ^{adr[AW-1:ADR_MSB+1], adr[1:0]};
    assign busy       = state_q != IDLE;
    // A request is only seen when no response went out last cycle, so a held strobe alternates.
    assign req        = wb.wb_cyc_i & wb.wb_stb_i & ~(ack_q | err_q);
    assign is_msg     = (idx_w >= 32'd2) & (idx_w < DIG_LO);
    assign is_dig     = (idx_w >= DIG_LO) & (idx_w < NW);
    assign bad        = (idx_w >= NW) | (wb.wb_we_i & (is_dig | (is_msg & busy)));
    assign wr_ok      = req & wb.wb_we_i & ~bad;
    assign ctrl_wr    = wr_ok & (idx_w == 32'd0) & wb.wb_sel_i[0];
    assign stat_wr    = wr_ok & (idx_w == 32'd1);
    assign start_wr   = ctrl_wr & wb.wb_dat_i[0];
    assign capture    = (state_q == BUSY) & core_valid_i;
    assign lane_mask  = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}}, {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};
    assign rdata      = rmap[idx];
    assign dig_d      = capture ? core_digest_i : dig_q;

    for (genvar i = 0; i < 2**IW; i++) begin : g_map
        if (i == 0) begin : g_ctrl
            assign rmap[i] = {29'b0, ie_q, busy, core_ready_i};
        end else if (i == 1) begin : g_stat
            assign rmap[i] = {30'b0, ovr_q, done_q};
        end else if (i < 2 + BLOCK_WORDS) begin : g_msgr
            assign rmap[i] = msg_q[i-2];
        end else if (i < 2 + BLOCK_WORDS + DIGEST_WORDS) begin : g_digr
            assign rmap[i] = dig_q[i-2-BLOCK_WORDS];
        end else begin : g_none
            assign rmap[i] = '0;
        end
    end

    for (genvar w = 0; w < BLOCK_WORDS; w++) begin : g_msg
        assign msg_d[w] = (wr_ok && idx_w == 32'(w + 2)) ?
                          (msg_q[w] & ~lane_mask) | (wb.wb_dat_i & lane_mask) : msg_q[w];
    end

    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        newmsg_d = 1'b0;
        lat_d    = lat_q;
        ack_d    = req & ~bad;
        err_d    = req & bad;
        dat_d    = ack_d ? rdata : '0;
        ie_d     = ctrl_wr ? wb.wb_dat_i[2] : ie_q;
        // Set terms are OR-ed after the W1C mask so a simultaneous set wins.
        done_d   = (done_q & ~(stat_wr & wb.wb_dat_i[0])) | capture;
        ovr_d    = (ovr_q & ~(stat_wr & wb.wb_dat_i[1])) | (start_wr & busy);
        case (state_q)
            IDLE: if (start_wr) begin
                lat_d    = wb.wb_dat_i[1];
                start_d  = core_ready_i;
                newmsg_d = core_ready_i & wb.wb_dat_i[1];
                state_d  = core_ready_i ? BUSY : PEND;
            end
            PEND: if (core_ready_i) begin
                start_d  = 1'b1;
                newmsg_d = lat_q;
                state_d  = BUSY;
            end
            BUSY: if (core_valid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q  <= IDLE;
            msg_q    <= '0;
            dig_q    <= '0;
            dat_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            ie_q     <= 1'b0;
            start_q  <= 1'b0;
            newmsg_q <= 1'b0;
            lat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            msg_q    <= msg_d;
            dig_q    <= dig_d;
            dat_q    <= dat_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            ie_q     <= ie_d;
            start_q  <= start_d;
            newmsg_q <= newmsg_d;
            lat_q    <= lat_d;
        end
    end

    assign wb.wb_dat_o   = dat_q;
    assign wb.wb_ack_o   = ack_q;
    assign wb.wb_err_o   = err_q;
    assign int_o         = done_q & ie_q;
    assign core_msg_o    = msg_q;
    assign core_start_o  = start_q;
    assign core_newmsg_o = newmsg_q;
endmodule

// File: tb/tb_wb_hash_ctrl_gen2.sv
// tb_wb_hash_ctrl_gen2: randomized scoreboard bench for wb_hash_ctrl_gen2 against a register-level reference model.
module tb_wb_hash_ctrl_gen2;
    localparam int BW      = 16;
    localparam int DW      = 4;
    localparam int NW      = 2 + BW + DW;
    localparam int ADR_MSB = $clog2(NW) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic core_ready_i = 1'b1;
    logic core_valid_i = 1'b0;
    logic [32*DW-1:0] core_digest_i = '0;
    logic [32*BW-1:0] core_msg_o;
    logic core_start_o, core_newmsg_o, int_o;

    always #5 clk = ~clk;

    wb_hash_ctrl_gen2_if #(.AW(32)) wbif ();

    wb_hash_ctrl_gen2 #(.BLOCK_WORDS(BW), .DIGEST_WORDS(DW), .AW(32)) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .wb           (wbif),
        .int_o        (int_o),
        .core_msg_o   (core_msg_o),
        .core_start_o (core_start_o),
        .core_newmsg_o(core_newmsg_o),
        .core_ready_i (core_ready_i),
        .core_digest_i(core_digest_i),
        .core_valid_i (core_valid_i)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: registers as the bus sees them, phase 0=idle 1=waiting for ready 2=hashing
    int               m_phase = 0;
    logic             m_done = 0, m_ovr = 0, m_ie = 0, m_lat = 0, m_resp_last = 0;
    logic [32*BW-1:0] m_msg = '0;
    logic [32*DW-1:0] m_dig = '0;
    logic [33:0]      rq[$];
    logic             sq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_done = 0; m_ovr = 0; m_ie = 0; m_lat = 0; m_resp_last = 0;
        m_msg = '0; m_dig = '0;
        rq.delete(); sq.delete();
    endtask

    task automatic model_step();
        int idx, p, sh;
        logic req, we, err, is_msg, is_dig, start_req, nm;
        logic [31:0] rd, dat, mask;
        logic [32*BW-1:0] wm;
        idx = int'(wbif.wb_adr_i[ADR_MSB:2]);
        we  = wbif.wb_we_i;
        dat = wbif.wb_dat_i;
        req = wbif.wb_cyc_i && wbif.wb_stb_i && !m_resp_last;
        m_resp_last = req;
        p = m_phase;
        is_msg = idx >= 2 && idx < 2 + BW;
        is_dig = idx >= 2 + BW && idx < NW;
        err = idx >= NW || (we && is_dig) || (we && is_msg && p != 0);
        if (idx == 0)      rd = {29'b0, m_ie, p != 0, core_ready_i};
        else if (idx == 1) rd = {30'b0, m_ovr, m_done};
        else if (is_msg)   rd = 32'(m_msg >> (32 * (idx - 2)));
        else if (is_dig)   rd = 32'(m_dig >> (32 * (idx - 2 - BW)));
        else               rd = 32'h0;
        if (req) rq.push_back({!err, err, err ? 32'h0 : rd});
        start_req = 0;
        nm = 0;
        if (req && !err && we) begin
            if (idx == 0 && wbif.wb_sel_i[0]) begin
                m_ie = dat[2];
                if (dat[0] && p == 0) begin
                    start_req = 1;
                    nm = dat[1];
                end
            end
            if (idx == 1) begin
                if (dat[0]) m_done = 0;
                if (dat[1]) m_ovr = 0;
            end
            if (is_msg) begin
                mask = 32'h0;
                for (int b = 0; b < 4; b++) if (wbif.wb_sel_i[b]) mask = mask | (32'hFF << (8 * b));
                sh = 32 * (idx - 2);
                wm = (32*BW)'(mask) << sh;
                m_msg = (m_msg & ~wm) | (((32*BW)'(dat)) << sh & wm);
            end
        end
        if (req && !err && we && idx == 0 && wbif.wb_sel_i[0] && dat[0] && p != 0) m_ovr = 1;
        if (p == 2 && core_valid_i) begin
            m_done = 1;
            m_dig = core_digest_i;
            m_phase = 0;
        end
        if (p == 0 && start_req) begin
            if (core_ready_i) begin
                sq.push_back(nm);
                m_phase = 2;
            end else begin
                m_lat = nm;
                m_phase = 1;
            end
        end else if (p == 1 && core_ready_i) begin
            sq.push_back(m_lat);
            m_phase = 2;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    // Monitor: pops expectations whenever the DUT should or does present an output
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (rq.size() > 0) chk("bus_resp", 64'({wbif.wb_ack_o, wbif.wb_err_o, wbif.wb_dat_o}), 64'(rq.pop_front()));
            else if (wbif.wb_ack_o || wbif.wb_err_o) chk("unexpected_resp", 64'({wbif.wb_ack_o, wbif.wb_err_o}), 64'h0);
            if (core_start_o) begin
                if (sq.size() == 0) chk("unexpected_start", 64'(core_start_o), 64'h0);
                else chk("start_newmsg", 64'(core_newmsg_o), 64'(sq.pop_front()));
            end
            chk("int_o", 64'(int_o), 64'(m_done & m_ie));
        end
    end

    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic v = 1'b0);
        @(negedge clk);
        wbif.wb_cyc_i = 1; wbif.wb_stb_i = 1; wbif.wb_we_i = we;
        wbif.wb_adr_i = adr; wbif.wb_dat_i = dat; wbif.wb_sel_i = sel;
        core_valid_i = v;
        @(negedge clk);
        wbif.wb_cyc_i = 0; wbif.wb_stb_i = 0; wbif.wb_we_i = 0;
        core_valid_i = 0;
    endtask

    task automatic set_digest(input logic [31:0] base, input logic rnd);
        logic [32*DW-1:0] dg;
        dg = '0;
        for (int i = DW - 1; i >= 0; i--) dg = (dg << 32) | (32*DW)'(rnd ? $urandom : base + 32'(i));
        core_digest_i = dg;
    endtask

    task automatic pulse_valid();
        @(negedge clk);
        core_valid_i = 1;
        @(negedge clk);
        core_valid_i = 0;
    endtask

    task automatic check_msg();
        for (int w = 0; w < BW; w++)
            chk($sformatf("core_msg[%0d]", w), 64'(32'(core_msg_o >> (32 * w))), 64'(32'(m_msg >> (32 * w))));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        wbif.wb_cyc_i = 0; wbif.wb_stb_i = 0; wbif.wb_we_i = 0;
        wbif.wb_adr_i = '0; wbif.wb_dat_i = '0; wbif.wb_sel_i = '0;
        idle(3);
        chk("rst_ack", 64'(wbif.wb_ack_o), 64'h0);
        chk("rst_start", 64'(core_start_o), 64'h0);
        chk("rst_int", 64'(int_o), 64'h0);
        chk("rst_msg_zero", 64'(core_msg_o == '0), 64'h1);
        rst_n = 1;
        bus(0, 32'h0, 0, 4'hF);
        bus(0, 32'h4, 0, 4'hF);
        for (int i = 0; i < BW; i++) bus(1, 32'(8 + 4 * i), 32'h1000_0000 + 32'(i), 4'hF);
        check_msg();
        set_digest(32'hA5A5_0000, 0);
        bus(1, 32'h0, 32'h7, 4'hF);
        idle(2);
        bus(0, 32'h0, 0, 4'hF);
        pulse_valid();
        bus(0, 32'h4, 0, 4'hF);
        bus(0, 32'(4 * (2 + BW)), 0, 4'hF);
        bus(1, 32'h14, 32'h0, 4'hF);
        bus(1, 32'h14, 32'hDEADBEEF, 4'b0101);
        bus(0, 32'h14, 0, 4'hF);
        bus(1, 32'h0, 32'h1, 4'hF);
        bus(1, 32'h14, 32'h1234_5678, 4'hF);
        bus(0, 32'h14, 0, 4'hF);
        check_msg();
        pulse_valid();
        @(negedge clk) core_ready_i = 0;
        bus(1, 32'h0, 32'h3, 4'hF);
        idle(5);
        bus(0, 32'h0, 0, 4'hF);
        @(negedge clk) core_ready_i = 1;
        idle(3);
        bus(1, 32'h4, 32'h3, 4'hF);
        bus(1, 32'h0, 32'h1, 4'hF);
        bus(0, 32'h4, 0, 4'hF);
        set_digest(0, 1);
        bus(1, 32'h4, 32'h1, 4'hF, 1'b1);
        bus(0, 32'h4, 0, 4'hF);
        bus(1, 32'h0, 32'h1, 4'hF);
        bus(1, 32'h0, 32'h1, 4'hF, 1'b1);
        bus(0, 32'h4, 0, 4'hF);
        bus(0, 32'h58, 0, 4'hF);
        bus(1, 32'(4 * (2 + BW)), 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        wbif.wb_cyc_i = 1; wbif.wb_stb_i = 1; wbif.wb_adr_i = 32'h4;
        idle(4);
        wbif.wb_cyc_i = 0; wbif.wb_stb_i = 0;
        bus(1, 32'h0, 32'h5, 4'hF);
        idle(3);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_ack", 64'(wbif.wb_ack_o | wbif.wb_err_o), 64'h0);
        chk("arst_dat", 64'(wbif.wb_dat_o), 64'h0);
        chk("arst_int", 64'(int_o), 64'h0);
        chk("arst_start", 64'(core_start_o), 64'h0);
        chk("arst_msg_zero", 64'(core_msg_o == '0), 64'h1);
        @(negedge clk) rst_n = 1;
        pulse_valid();
        bus(0, 32'h4, 0, 4'hF);
        bus(0, 32'h0, 0, 4'hF);
        for (int n = 0; n < 400; n++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0, 1: begin
                    a[ADR_MSB:2] = 5'($urandom_range(2, 1 + BW));
                    bus(1, a, $urandom, 4'($urandom_range(0, 15)));
                end
                2: begin
                    a[ADR_MSB:2] = 5'($urandom_range(0, NW + 3));
                    bus(0, a, $urandom, 4'hF);
                end
                3: begin
                    a[ADR_MSB:2] = 5'd0;
                    set_digest(0, 1);
                    bus(1, a, $urandom_range(0, 7), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                end
                4: begin
                    a[ADR_MSB:2] = 5'd1;
                    bus(1, a, $urandom_range(0, 3), 4'($urandom_range(0, 15)));
                end
                5: @(negedge clk) core_ready_i = 1'($urandom_range(0, 1));
                6: begin
                    set_digest(0, 1);
                    pulse_valid();
                end
                default: begin
                    a[ADR_MSB:2] = 5'($urandom_range(0, NW + 3));
                    set_digest(0, 1);
                    bus(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                end
            endcase
        end
        @(negedge clk) core_ready_i = 1;
        idle(4);
        check_msg();
        chk("resp_queue_empty", 64'(rq.size()), 64'h0);
        chk("start_queue_empty", 64'(sq.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
